// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-port arbiter sharing one cartridge RAM port
// Port A has fixed priority, port B is protected by a starvation guard.
module ram_port_arbiter #(
   parameter int ADDR_WIDTH   = 22,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_a_req,
   input  logic [ADDR_WIDTH-1:0] i_a_addr,
   input  logic                  i_a_we,
   input  logic [7:0]            i_a_din,
   output logic [7:0]            o_a_dout,
   output logic                  o_a_ack,
   input  logic                  i_b_req,
   input  logic [ADDR_WIDTH-1:0] i_b_addr,
   input  logic                  i_b_we,
   input  logic [7:0]            i_b_din,
   output logic [7:0]            o_b_dout,
   output logic                  o_b_ack,
   output logic                  o_ram_req,
   output logic [ADDR_WIDTH-1:0] o_ram_addr,
   output logic                  o_ram_we,
   output logic [7:0]            o_ram_din,
   input  logic [7:0]            i_ram_dout,
   input  logic                  i_ram_ack,
   output logic                  o_timeout_err
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

   localparam logic [3:0] STARVE  = 4'(STARVE_LIMIT);
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t                r_state;
   logic                  r_win_b;
   logic [3:0]            r_run_cnt;
   logic [7:0]            r_wait_cnt;
   logic                  r_ram_req;
   logic [ADDR_WIDTH-1:0] r_ram_addr;
   logic                  r_ram_we;
   logic [7:0]            r_ram_din;
   logic                  r_a_ack;
   logic                  r_b_ack;
   logic [7:0]            r_a_dout;
   logic [7:0]            r_b_dout;
   logic                  r_timeout_err;

   logic w_grant_b;
   logic w_timeout_hit;

   // B wins only when A is idle or A has used up its run of consecutive grants
   assign w_grant_b     = i_b_req && (!i_a_req || (r_run_cnt == STARVE));
   assign w_timeout_hit = (TIMEOUT != 0) && (r_wait_cnt == TO_LAST);

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state       <= S_IDLE;
         r_win_b       <= 1'b0;
         r_run_cnt     <= 4'd0;
         r_wait_cnt    <= 8'd0;
         r_ram_req     <= 1'b0;
         r_ram_addr    <= '0;
         r_ram_we      <= 1'b0;
         r_ram_din     <= 8'h00;
         r_a_ack       <= 1'b0;
         r_b_ack       <= 1'b0;
         r_a_dout      <= 8'h00;
         r_b_dout      <= 8'h00;
         r_timeout_err <= 1'b0;
      end else begin
         r_a_ack       <= 1'b0;
         r_b_ack       <= 1'b0;
         r_timeout_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_a_req || i_b_req) begin
                  r_win_b    <= w_grant_b;
                  r_ram_addr <= w_grant_b ? i_b_addr : i_a_addr;
                  r_ram_we   <= w_grant_b ? i_b_we   : i_a_we;
                  r_ram_din  <= w_grant_b ? i_b_din  : i_a_din;
                  r_ram_req  <= 1'b1;
                  r_wait_cnt <= 8'd0;
                  r_state    <= S_ISSUE;
                  if (w_grant_b || !i_b_req)
                     r_run_cnt <= 4'd0;
                  else if (r_run_cnt != STARVE)
                     r_run_cnt <= r_run_cnt + 4'd1;
               end
            end
            S_ISSUE: begin
               if (i_ram_ack) begin
                  r_ram_req <= 1'b0;
                  r_a_ack   <= !r_win_b;
                  r_b_ack   <= r_win_b;
                  if (!r_ram_we) begin
                     if (r_win_b) r_b_dout <= i_ram_dout;
                     else         r_a_dout <= i_ram_dout;
                  end
                  r_state <= S_DONE;
               end else if (w_timeout_hit) begin
                  r_ram_req     <= 1'b0;
                  r_a_ack       <= !r_win_b;
                  r_b_ack       <= r_win_b;
                  r_timeout_err <= 1'b1;
                  if (r_win_b) r_b_dout <= 8'hFF;
                  else         r_a_dout <= 8'hFF;
                  r_state <= S_DONE;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 8'd1;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_ram_req     = r_ram_req;
   assign o_ram_addr    = r_ram_addr;
   assign o_ram_we      = r_ram_we;
   assign o_ram_din     = r_ram_din;
   assign o_a_ack       = r_a_ack;
   assign o_b_ack       = r_b_ack;
   assign o_a_dout      = r_a_dout;
   assign o_b_dout      = r_b_dout;
   assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed vector bench for ram_port_arbiter
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        a_req, a_we, b_req, b_we, ram_ack;
   logic [21:0] a_addr, b_addr;
   logic [7:0]  a_din, b_din, ram_dout;
   logic [7:0]  a_dout, b_dout, ram_din;
   logic        a_ack, b_ack, ram_req, ram_we, timeout_err;
   logic [21:0] ram_addr;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(.ADDR_WIDTH(22), .STARVE_LIMIT(4), .TIMEOUT(8)) dut (
      .i_clk(clk), .i_reset_n(resetn),
      .i_a_req(a_req), .i_a_addr(a_addr), .i_a_we(a_we), .i_a_din(a_din),
      .o_a_dout(a_dout), .o_a_ack(a_ack),
      .i_b_req(b_req), .i_b_addr(b_addr), .i_b_we(b_we), .i_b_din(b_din),
      .o_b_dout(b_dout), .o_b_ack(b_ack),
      .o_ram_req(ram_req), .o_ram_addr(ram_addr), .o_ram_we(ram_we), .o_ram_din(ram_din),
      .i_ram_dout(ram_dout), .i_ram_ack(ram_ack), .o_timeout_err(timeout_err)
   );

   typedef struct {
      logic        a_req;
      logic [21:0] a_addr;
      logic        a_we;
      logic [7:0]  a_din;
      logic        b_req;
      logic [21:0] b_addr;
      logic        b_we;
      logic [7:0]  b_din;
      int          delay;
      logic [7:0]  rd;
      logic        drop;
      logic        exp_b;
      logic [21:0] exp_addr;
      logic        exp_we;
      logic [7:0]  exp_din;
      logic [7:0]  exp_a_dout;
      logic [7:0]  exp_b_dout;
   } vec_t;

   vec_t vecs [8];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic apply_vec(input vec_t v);
      a_req = v.a_req; a_addr = v.a_addr; a_we = v.a_we; a_din = v.a_din;
      b_req = v.b_req; b_addr = v.b_addr; b_we = v.b_we; b_din = v.b_din;
      ram_ack = 1'b0;
      step();
      check("issue_req",  32'(ram_req),  32'd1);
      check("issue_addr", 32'(ram_addr), 32'(v.exp_addr));
      check("issue_we",   32'(ram_we),   32'(v.exp_we));
      check("issue_din",  32'(ram_din),  32'(v.exp_din));
      if (v.drop) begin
         a_req = 1'b0;
         b_req = 1'b0;
      end
      for (int i = 0; i < v.delay; i++) begin
         step();
         check("wait_req", 32'({ram_req, a_ack, b_ack}), 32'b100);
         check("wait_addr", 32'(ram_addr), 32'(v.exp_addr));
      end
      ram_ack  = 1'b1;
      ram_dout = v.rd;
      step();
      ram_ack = 1'b0;
      check("done_a_ack",  32'(a_ack),       32'(!v.exp_b));
      check("done_b_ack",  32'(b_ack),       32'(v.exp_b));
      check("done_ramreq", 32'(ram_req),     32'd0);
      check("done_err",    32'(timeout_err), 32'd0);
      check("done_a_dout", 32'(a_dout),      32'(v.exp_a_dout));
      check("done_b_dout", 32'(b_dout),      32'(v.exp_b_dout));
      a_req = 1'b0;
      b_req = 1'b0;
      step();
      check("ack_one_cycle", 32'({a_ack, b_ack}), 32'd0);
   endtask

   initial begin
      logic grants [$];
      int   cnt;
      logic exp_order [10];
      vec_t v;

      //         a_req a_addr      we   din    b_req b_addr      we   din    dly rd     drop  exp_b exp_addr    we   din    a_dout b_dout
      vecs[0] = '{1'b1, 22'h012345, 1'b0, 8'h00, 1'b0, 22'h000000, 1'b0, 8'h00, 2, 8'h5A, 1'b0, 1'b0, 22'h012345, 1'b0, 8'h00, 8'h5A, 8'h00};
      vecs[1] = '{1'b0, 22'h000000, 1'b0, 8'h00, 1'b1, 22'h3FFFFF, 1'b1, 8'hC3, 0, 8'hEE, 1'b0, 1'b1, 22'h3FFFFF, 1'b1, 8'hC3, 8'h5A, 8'h00};
      vecs[2] = '{1'b0, 22'h000000, 1'b0, 8'h00, 1'b1, 22'h000001, 1'b0, 8'h00, 1, 8'h77, 1'b0, 1'b1, 22'h000001, 1'b0, 8'h00, 8'h5A, 8'h77};
      vecs[3] = '{1'b1, 22'h2AAAAA, 1'b1, 8'h99, 1'b0, 22'h000000, 1'b0, 8'h00, 0, 8'hE1, 1'b0, 1'b0, 22'h2AAAAA, 1'b1, 8'h99, 8'h5A, 8'h77};
      vecs[4] = '{1'b1, 22'h111111, 1'b0, 8'h00, 1'b1, 22'h222222, 1'b1, 8'h44, 0, 8'h81, 1'b0, 1'b0, 22'h111111, 1'b0, 8'h00, 8'h81, 8'h77};
      vecs[5] = '{1'b0, 22'h000000, 1'b0, 8'h00, 1'b1, 22'h000ABC, 1'b0, 8'h00, 3, 8'h0F, 1'b1, 1'b1, 22'h000ABC, 1'b0, 8'h00, 8'h81, 8'h0F};
      vecs[6] = '{1'b1, 22'h3ABCDE, 1'b0, 8'h00, 1'b0, 22'h000000, 1'b0, 8'h00, 7, 8'h11, 1'b0, 1'b0, 22'h3ABCDE, 1'b0, 8'h00, 8'h11, 8'h0F};
      vecs[7] = '{1'b1, 22'h000000, 1'b0, 8'h5E, 1'b0, 22'h000000, 1'b0, 8'h00, 6, 8'h22, 1'b0, 1'b0, 22'h000000, 1'b0, 8'h5E, 8'h22, 8'h0F};

      exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      resetn = 1'b0;
      a_req = 1'b0; a_addr = '0; a_we = 1'b0; a_din = 8'h00;
      b_req = 1'b0; b_addr = '0; b_we = 1'b0; b_din = 8'h00;
      ram_ack = 1'b0; ram_dout = 8'h00;
      step();
      step();
      resetn = 1'b1;
      check("reset_outputs", 32'({ram_req, ram_we, a_ack, b_ack, timeout_err}), 32'd0);
      check("reset_addr",    32'(ram_addr), 32'd0);
      check("reset_data",    32'({ram_din, a_dout, b_dout}), 32'd0);

      foreach (vecs[i]) apply_vec(vecs[i]);

      // Both ports held: A gets four grants in a row, then B
      ram_dout = 8'h3C;
      a_we = 1'b0; b_we = 1'b0;
      a_req = 1'b1; b_req = 1'b1;
      ram_ack = 1'b1;
      cnt = 0;
      while (grants.size() < 10 && cnt < 60) begin
         step();
         cnt++;
         if (a_ack) grants.push_back(1'b0);
         if (b_ack) grants.push_back(1'b1);
      end
      a_req = 1'b0; b_req = 1'b0;
      check("starve_grant_count", 32'(grants.size()), 32'd10);
      for (int i = 0; i < 10; i++)
         if (i < grants.size()) check($sformatf("starve_order[%0d]", i), 32'(grants[i]), 32'(exp_order[i]));
      step();
      step();
      ram_ack = 1'b0;
      check("starve_douts", 32'({a_dout, b_dout}), 32'h3C3C);

      // RAM never answers: request held for TIMEOUT cycles then aborted
      a_req = 1'b1; a_addr = 22'h000100; a_we = 1'b0;
      step();
      cnt = 0;
      while (ram_req === 1'b1 && cnt < 20) begin
         cnt++;
         step();
      end
      check("timeout_req_cycles", 32'(cnt), 32'd8);
      check("timeout_a_ack", 32'(a_ack), 32'd1);
      check("timeout_b_ack", 32'(b_ack), 32'd0);
      check("timeout_dout",  32'(a_dout), 32'hFF);
      check("timeout_err",   32'(timeout_err), 32'd1);
      a_req = 1'b0;
      step();
      check("timeout_err_pulse", 32'(timeout_err), 32'd0);

      v = '{1'b1, 22'h000042, 1'b0, 8'h00, 1'b0, 22'h000000, 1'b0, 8'h00, 0, 8'h42, 1'b0, 1'b0, 22'h000042, 1'b0, 8'h00, 8'h42, 8'h3C};
      apply_vec(v);

      // Reset during ISSUE aborts without ACK; later stray RAM_ACK ignored
      a_req = 1'b1; a_addr = 22'h000200;
      step();
      check("pre_reset_req", 32'(ram_req), 32'd1);
      resetn = 1'b0;
      a_req = 1'b0;
      step();
      resetn = 1'b1;
      check("rst_ctrl",  32'({ram_req, ram_we, a_ack, b_ack, timeout_err}), 32'd0);
      check("rst_addr",  32'(ram_addr), 32'd0);
      check("rst_data",  32'({ram_din, a_dout, b_dout}), 32'd0);
      ram_ack = 1'b1; ram_dout = 8'h99;
      step();
      ram_ack = 1'b0;
      check("stray_ack",  32'({ram_req, a_ack, b_ack}), 32'd0);
      check("stray_dout", 32'({a_dout, b_dout}), 32'd0);
      step();
      check("stray_ack_later", 32'({a_ack, b_ack, timeout_err}), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
